// File: rtl/uart_pkt_gen.sv
// uart_pkt_gen: on each vsync rising edge, sends the target-box centres as a UART byte packet.
// Defining UART_PKT_CHKSUM_EN appends a modulo-256 checksum byte.
module uart_pkt_gen #(
  parameter int NUM_TGT = 2,
  parameter int X_W = 11,
  parameter int Y_W = 10,
  parameter logic [7:0] HDR0 = 8'hFF,
  parameter logic [7:0] HDR1 = 8'hA5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vsync_i,
  input  logic [NUM_TGT*2*(X_W+Y_W)-1:0]  tgt_box,
  input  logic [NUM_TGT-1:0]              tgt_valid,
  input  logic                            tx_busy,
  output logic [7:0]                      write_data,
  output logic                            write_en,
  output logic                            busy,
  output logic                            pkt_done,
  output logic                            frame_drop
);
  localparam int BW = 2*(X_W+Y_W);
`ifdef UART_PKT_CHKSUM_EN
  localparam int LEN = 5 + 5*NUM_TGT;
`else
  localparam int LEN = 4 + 5*NUM_TGT;
`endif
  localparam int IW = $clog2(LEN+1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_DONE} state_t;
  state_t             r_state;
  logic               r_vsync_d;
  logic               r_txb_d;
  logic [7:0]         r_frame;
  logic [IW-1:0]      r_idx;
  logic [NUM_TGT-1:0] r_valid;
  logic [15:0]        r_cx [NUM_TGT];
  logic [15:0]        r_cy [NUM_TGT];
`ifdef UART_PKT_CHKSUM_EN
  logic [7:0]         r_sum;
`endif
  logic [X_W-1:0]     w_cx [NUM_TGT];
  logic [Y_W-1:0]     w_cy [NUM_TGT];
  logic [7:0]         w_byte;
  logic               w_vedge;
  logic               w_tfall;
  assign w_vedge = vsync_i & ~r_vsync_d;
  assign w_tfall = ~tx_busy & r_txb_d;
  // Sums are one bit wider than the coordinate, so the halved result never wraps.
  for (genvar g = 0; g < NUM_TGT; g++) begin : g_ctr
    assign w_cx[g] = X_W'(((X_W+1)'(tgt_box[g*BW +: X_W]) + (X_W+1)'(tgt_box[g*BW+X_W+Y_W +: X_W])) >> 1);
    assign w_cy[g] = Y_W'(((Y_W+1)'(tgt_box[g*BW+X_W +: Y_W]) + (Y_W+1)'(tgt_box[g*BW+2*X_W+Y_W +: Y_W])) >> 1);
  end
  always_comb begin
    w_byte = r_idx == IW'(0) ? HDR0 :
             r_idx == IW'(1) ? HDR1 :
             r_idx == IW'(2) ? r_frame :
             r_idx == IW'(3) ? 8'(NUM_TGT) : 8'h00;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (r_idx == IW'(4+5*t)) w_byte = {7'd0, r_valid[t]};
      if (r_idx == IW'(5+5*t)) w_byte = r_cx[t][15:8];
      if (r_idx == IW'(6+5*t)) w_byte = r_cx[t][7:0];
      if (r_idx == IW'(7+5*t)) w_byte = r_cy[t][15:8];
      if (r_idx == IW'(8+5*t)) w_byte = r_cy[t][7:0];
    end
`ifdef UART_PKT_CHKSUM_EN
    if (r_idx == IW'(LEN-1)) w_byte = r_sum;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_vsync_d  <= 1'b0;
      r_txb_d    <= 1'b0;
      r_frame    <= 8'd0;
      r_idx      <= '0;
      write_en   <= 1'b0;
      write_data <= 8'd0;
      busy       <= 1'b0;
      pkt_done   <= 1'b0;
      frame_drop <= 1'b0;
`ifdef UART_PKT_CHKSUM_EN
      r_sum      <= 8'd0;
`endif
    end else begin
      r_vsync_d  <= vsync_i;
      r_txb_d    <= tx_busy;
      write_en   <= 1'b0;
      pkt_done   <= 1'b0;
      frame_drop <= w_vedge && r_state != S_IDLE;
      case (r_state)
        S_IDLE: if (w_vedge) begin
          r_state <= S_LOAD;
          busy    <= 1'b1;
          r_idx   <= '0;
        end
        S_LOAD: begin
          for (int t = 0; t < NUM_TGT; t++) begin
            r_cx[t] <= tgt_valid[t] ? 16'(w_cx[t]) : 16'd0;
            r_cy[t] <= tgt_valid[t] ? 16'(w_cy[t]) : 16'd0;
          end
          r_valid    <= tgt_valid;
          r_state    <= S_SEND;
          write_en   <= 1'b1;
          write_data <= w_byte;
          r_idx      <= r_idx + 1'b1;
`ifdef UART_PKT_CHKSUM_EN
          r_sum      <= 8'd0;
`endif
        end
        S_SEND: r_state <= S_WAIT;
        S_WAIT: if (w_tfall) begin
          if (r_idx == IW'(LEN)) begin
            r_state  <= S_DONE;
            pkt_done <= 1'b1;
          end else begin
            r_state    <= S_SEND;
            write_en   <= 1'b1;
            write_data <= w_byte;
            r_idx      <= r_idx + 1'b1;
`ifdef UART_PKT_CHKSUM_EN
            if (r_idx >= IW'(2) && r_idx <= IW'(LEN-2)) r_sum <= r_sum + w_byte;
`endif
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          r_frame <= r_frame + 8'd1;
          r_idx   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_pkt_gen.sv
// tb_uart_pkt_gen: directed and randomized packet checks against a byte-list reference model.
module tb_uart_pkt_gen;
  localparam int NT = 2, XW = 11, YW = 10, BW = 2*(XW+YW);
`ifdef UART_PKT_CHKSUM_EN
  localparam int LEN = 5 + 5*NT;
`else
  localparam int LEN = 4 + 5*NT;
`endif
  logic clk = 0, reset = 1, vsync_i = 0, tx_busy = 0;
  logic [NT*BW-1:0] tgt_box = '0;
  logic [NT-1:0] tgt_valid = '0;
  logic [7:0] write_data;
  logic write_en, busy, pkt_done, frame_drop;
  uart_pkt_gen dut (
    .clk(clk), .reset(reset), .vsync_i(vsync_i), .tgt_box(tgt_box), .tgt_valid(tgt_valid),
    .tx_busy(tx_busy), .write_data(write_data), .write_en(write_en), .busy(busy),
    .pkt_done(pkt_done), .frame_drop(frame_drop)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  int cyc = 0, tx_cnt = 0, tx_len = 10, done_n = 0, done_cyc = 0, drop_n = 0;
  int ecyc = 0, dstart = 0;
  bit hold = 0;
  logic [7:0] bq[$], exp_q[$], lit[$];
  int wcyc[$];
  int tx0[NT], tx1[NT], ty0[NT], ty1[NT];
  bit tv[NT];
  logic [7:0] frame = 0;
  // UART stand-in: busy for tx_len cycles after each write, or while held.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (write_en === 1'b1) begin
      bq.push_back(write_data);
      wcyc.push_back(cyc);
      tx_cnt = tx_len;
    end else if (tx_cnt > 0) tx_cnt--;
    tx_busy = hold || tx_cnt > 0;
    if (pkt_done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
    if (frame_drop === 1'b1) drop_n++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pack();
    for (int i = 0; i < NT; i++) begin
      tgt_box[i*BW +: XW]         = XW'(tx0[i]);
      tgt_box[i*BW+XW +: YW]      = YW'(ty0[i]);
      tgt_box[i*BW+XW+YW +: XW]   = XW'(tx1[i]);
      tgt_box[i*BW+2*XW+YW +: YW] = YW'(ty1[i]);
      tgt_valid[i] = tv[i];
    end
  endtask
  task automatic rand_tgts();
    for (int i = 0; i < NT; i++) begin
      tx0[i] = $urandom_range(0, (1 << XW) - 1);
      tx1[i] = $urandom_range(0, (1 << XW) - 1);
      ty0[i] = $urandom_range(0, (1 << YW) - 1);
      ty1[i] = $urandom_range(0, (1 << YW) - 1);
      tv[i]  = 1'($urandom_range(0, 1));
    end
    pack();
  endtask
  task automatic build_exp();
    int cx, cy;
    logic [7:0] s;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hA5);
    exp_q.push_back(frame);
    exp_q.push_back(8'(NT));
    for (int i = 0; i < NT; i++) begin
      cx = tv[i] ? (tx0[i] + tx1[i]) / 2 : 0;
      cy = tv[i] ? (ty0[i] + ty1[i]) / 2 : 0;
      exp_q.push_back({7'd0, tv[i]});
      exp_q.push_back(8'(cx >> 8));
      exp_q.push_back(8'(cx));
      exp_q.push_back(8'(cy >> 8));
      exp_q.push_back(8'(cy));
    end
    s = 0;
    for (int k = 2; k < exp_q.size(); k++) s += exp_q[k];
`ifdef UART_PKT_CHKSUM_EN
    exp_q.push_back(s);
`endif
  endtask
  task automatic start_pkt();
    build_exp();
    bq.delete();
    wcyc.delete();
    dstart = done_n;
    tick();
    vsync_i = 0;
    tick();
    vsync_i = 1;
    ecyc = cyc;
  endtask
  task automatic wait_bytes(input int n);
    int t = 0;
    while (bq.size() < n && t < 2000) begin
      tick();
      t++;
    end
    if (bq.size() < n) check("wait_bytes", bq.size(), n);
  endtask
  task automatic finish_pkt();
    int t = 0;
    while (done_n == dstart && t < LEN*(tx_len+1) + 50) begin
      tick();
      t++;
    end
    check("pkt_done_count", done_n - dstart, 1);
    check("nbytes", bq.size(), exp_q.size());
    if (bq.size() == exp_q.size()) begin
      check("first_we_latency", wcyc[0] - ecyc, 2);
      check("pkt_done_gap", done_cyc - wcyc[LEN-1], tx_len + 1);
      for (int k = 0; k < LEN; k++) check($sformatf("byte%0d", k), bq[k], exp_q[k]);
    end
    frame++;
  endtask
  task automatic run_packet();
    start_pkt();
    finish_pkt();
  endtask
  initial begin
    int n0, d, target;
    repeat (3) tick();
    check("rst_write_en", write_en, 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_frame_drop", frame_drop, 0);
    reset = 0;
    tick();
    // Basic packet: target0 valid, target1 invalid with junk coordinates.
    tx0[0] = 100; tx1[0] = 200; ty0[0] = 50; ty1[0] = 150; tv[0] = 1;
    tx0[1] = $urandom_range(0, 2047); tx1[1] = $urandom_range(0, 2047);
    ty0[1] = $urandom_range(0, 1023); ty1[1] = $urandom_range(0, 1023); tv[1] = 0;
    pack();
    lit = '{8'hFF, 8'hA5, 8'h00, 8'h02, 8'h01, 8'h00, 8'h96, 8'h00, 8'h64,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef UART_PKT_CHKSUM_EN
    lit.push_back(8'hFD);
`endif
    start_pkt();
    tick();
    check("busy_in_load", busy, 1);
    finish_pkt();
    check("lit_len", bq.size(), lit.size());
    if (bq.size() == lit.size())
      for (int k = 0; k < lit.size(); k++) check($sformatf("lit%0d", k), bq[k], lit[k]);
    // Random packets, inputs scrambled mid-transmission.
    for (int r = 0; r < 6; r++) begin
      rand_tgts();
      start_pkt();
      repeat (3) tick();
      rand_tgts();
      finish_pkt();
    end
    // Maximum coordinates.
    for (int i = 0; i < NT; i++) begin
      tx0[i] = 2047; tx1[i] = 2047; ty0[i] = 1023; ty1[i] = 1023; tv[i] = 1;
    end
    pack();
    run_packet();
    if (bq.size() > 8) begin
      check("max_cx_hi", bq[5], 8'h07);
      check("max_cx_lo", bq[6], 8'hFF);
      check("max_cy_hi", bq[7], 8'h03);
      check("max_cy_lo", bq[8], 8'hFF);
    end
    // vsync edge during byte 5 is dropped; the packet continues unchanged.
    rand_tgts();
    start_pkt();
    wait_bytes(5);
    d = drop_n;
    vsync_i = 0;
    tick();
    vsync_i = 1;
    repeat (2) tick();
    check("drop_pulse", drop_n - d, 1);
    finish_pkt();
    // vsync edge landing in the DONE cycle is dropped too.
    rand_tgts();
    start_pkt();
    wait_bytes(LEN);
    vsync_i = 0;
    target = (wcyc.size() > 0) ? wcyc[wcyc.size()-1] + tx_len + 1 : cyc;
    while (cyc < target) tick();
    d = drop_n;
    vsync_i = 1;
    repeat (20) tick();
    check("done_edge_drop", drop_n - d, 1);
    check("done_edge_idle", busy, 0);
    finish_pkt();
    // tx_busy held high stalls the packet.
    rand_tgts();
    start_pkt();
    wait_bytes(3);
    hold = 1;
    repeat (2) tick();
    n0 = bq.size();
    repeat (60) tick();
    check("hold_no_we", bq.size(), n0);
    check("hold_busy", busy, 1);
    hold = 0;
    finish_pkt();
    // Reset after the 3rd byte aborts the packet and clears the frame counter.
    rand_tgts();
    start_pkt();
    wait_bytes(3);
    reset = 1;
    vsync_i = 0;
    tick();
    check("midrst_we", write_en, 0);
    check("midrst_busy", busy, 0);
    tick();
    reset = 0;
    repeat (40) tick();
    check("midrst_nbytes", bq.size(), 3);
    check("midrst_no_done", done_n, dstart);
    frame = 0;
    rand_tgts();
    run_packet();
    if (bq.size() > 2) check("midrst_frame_byte", bq[2], 8'h00);
    // Frame counter wrap: packet 257 after reset carries frame byte 00.
    tx_len = 2;
    while (frame != 8'h00) begin
      rand_tgts();
      run_packet();
    end
    rand_tgts();
    run_packet();
    if (bq.size() > 2) check("wrap_frame_byte", bq[2], 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
